// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: bus widths, load/store
// control encodings, FSM state codes and access-size helpers.
package mem_lsu_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int LS_BUS       = 3;

    // Load control encodings; 6 and 7 decode as "no load".
    typedef enum logic [LS_BUS-1:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } load_e;

    // Store control encodings; 4 to 7 decode as "no store".
    typedef enum logic [LS_BUS-1:0] {
        ST_NONE = 3'd0,
        ST_SB   = 3'd1,
        ST_SH   = 3'd2,
        ST_SW   = 3'd3
    } store_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    function automatic size_e load_size(input logic [LS_BUS-1:0] ctl);
        case (ctl)
            LD_LB, LD_LBU: load_size = SZ_BYTE;
            LD_LH, LD_LHU: load_size = SZ_HALF;
            LD_LW:         load_size = SZ_WORD;
            default:       load_size = SZ_NONE;
        endcase
    endfunction

    function automatic size_e store_size(input logic [LS_BUS-1:0] ctl);
        case (ctl)
            ST_SB:   store_size = SZ_BYTE;
            ST_SH:   store_size = SZ_HALF;
            ST_SW:   store_size = SZ_WORD;
            default: store_size = SZ_NONE;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = |lo;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational lane steering. The request side builds
// byte enables and replicated store data; the response side picks the
// addressed byte/half out of the read word and sign/zero-extends it.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]         req_addr_lo,
    input  logic [1:0]         req_size,
    input  logic [REG_BUS-1:0] storedata,
    output logic [3:0]         be,
    output logic [REG_BUS-1:0] wdata,
    input  logic [1:0]         rsp_addr_lo,
    input  logic [LS_BUS-1:0]  rsp_loadctl,
    input  logic [REG_BUS-1:0] rdata,
    output logic [REG_BUS-1:0] load_data
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    // Byte enables and lane-replicated store data from the access size.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        be    = 4'b0000;
        wdata = storedata;
        case (req_size)
            SZ_BYTE: begin
                be    = 4'b0001 << req_addr_lo;
                wdata = {4{storedata[7:0]}};
            end
            SZ_HALF: begin
                be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{storedata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        case (rsp_addr_lo)
            2'd0:    rsp_byte = rdata[7:0];
            2'd1:    rsp_byte = rdata[15:8];
            2'd2:    rsp_byte = rdata[23:16];
            default: rsp_byte = rdata[31:24];
        endcase
        rsp_half = rsp_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_loadctl)
            LD_LB:   load_data = {{24{rsp_byte[7]}}, rsp_byte};
            LD_LBU:  load_data = {24'd0, rsp_byte};
            LD_LH:   load_data = {{16{rsp_half[15]}}, rsp_half};
            LD_LHU:  load_data = {16'd0, rsp_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage load/store unit. Non-memory results pass to WB with one
// cycle of latency; a memop stalls upstream, captures its request, and holds
// dmem_req until dmem_ack, then writes the aligned load data (or nothing for
// a store) into the WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned halfword/word
// accesses are dropped without a memory request and flagged on misalign_o.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_BUS-1:0] rd,
    input  logic                    regwe,
    input  logic [REG_BUS-1:0]      result,
    input  logic [LS_BUS-1:0]       loadctl,
    input  logic [LS_BUS-1:0]       storectl,
    input  logic [REG_BUS-1:0]      storedata,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [REG_BUS-1:0]      dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [REG_BUS-1:0]      dmem_wdata,
    input  logic [REG_BUS-1:0]      dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stallreq,
    output logic [REG_ADDR_BUS-1:0] rd_o,
    output logic                    regwe_o,
    output logic [REG_BUS-1:0]      wbdata,
    output logic                    misalign_o
);

    state_e state, next_state;

    // Decoded request; a valid load takes priority over a valid store.
    size_e ld_size, st_size, req_size;
    logic  load_valid, store_valid, memop, misaligned, capture;

    // Captured request, held stable for the whole REQ phase.
    logic [REG_BUS-1:0]      cap_addr;
    logic [3:0]              cap_be;
    logic [REG_BUS-1:0]      cap_wdata;
    logic                    cap_we;
    logic [LS_BUS-1:0]       cap_loadctl;
    logic [REG_ADDR_BUS-1:0] cap_rd;
    logic                    cap_regwe;

    logic [3:0]              req_be;
    logic [REG_BUS-1:0]      req_wdata;
    logic [REG_BUS-1:0]      load_data;

    // Next values for the WB output register.
    logic [REG_ADDR_BUS-1:0] wb_rd;
    logic                    wb_regwe;
    logic [REG_BUS-1:0]      wb_data;

    assign ld_size     = load_size(loadctl);
    assign st_size     = store_size(storectl);
    assign load_valid  = (ld_size != SZ_NONE);
    assign store_valid = (st_size != SZ_NONE);
    assign memop       = load_valid | store_valid;
    assign req_size    = load_valid ? ld_size : st_size;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_size, result[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .req_addr_lo (result[1:0]),
        .req_size    (req_size),
        .storedata   (storedata),
        .be          (req_be),
        .wdata       (req_wdata),
        .rsp_addr_lo (cap_addr[1:0]),
        .rsp_loadctl (cap_loadctl),
        .rdata       (dmem_rdata),
        .load_data   (load_data)
    );

    assign dmem_addr  = {cap_addr[REG_BUS-1:2], 2'b00};
    assign dmem_be    = cap_be;
    assign dmem_we    = cap_we;
    assign dmem_wdata = cap_wdata;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state, handshake outputs and next WB register contents.
    always_comb begin
        next_state = state;
        dmem_req   = 1'b0;
        stallreq   = 1'b0;
        capture    = 1'b0;
        wb_rd      = rd_o;
        wb_regwe   = 1'b0;
        wb_data    = wbdata;
        case (state)
            S_IDLE: begin
                if (memop && !misaligned) begin
                    stallreq   = 1'b1;
                    capture    = 1'b1;
                    next_state = S_REQ;
                end else if (!memop) begin
                    wb_rd    = rd;
                    wb_regwe = regwe;
                    wb_data  = result;
                end
            end
            S_REQ: begin
                dmem_req = 1'b1;
                stallreq = ~dmem_ack;
                if (dmem_ack) begin
                    next_state = S_IDLE;
                    if (!cap_we) begin
                        wb_rd    = cap_rd;
                        wb_regwe = cap_regwe;
                        wb_data  = load_data;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Capture the memop request while leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr    <= '0;
            cap_be      <= '0;
            cap_wdata   <= '0;
            cap_we      <= 1'b0;
            cap_loadctl <= '0;
            cap_rd      <= '0;
            cap_regwe   <= 1'b0;
        end else if (capture) begin
            cap_addr    <= result;
            cap_be      <= req_be;
            cap_wdata   <= req_wdata;
            cap_we      <= ~load_valid;
            cap_loadctl <= load_valid ? loadctl : LD_NONE;
            cap_rd      <= rd;
            cap_regwe   <= regwe;
        end
    end

    // WB output register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge values.
        if (rst) begin
            rd_o    <= '0;
            regwe_o <= 1'b0;
            wbdata  <= '0;
        end else begin
            rd_o    <= wb_rd;
            regwe_o <= wb_regwe;
            wbdata  <= wb_data;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // One-cycle pulse for a misaligned memop dropped in IDLE.
    always_ff @(posedge clk) begin
        if (rst) misalign_o <= 1'b0;
        else     misalign_o <= (state == S_IDLE) && memop && misaligned;
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule
